// File: rtl/mat_mul_seq.sv
// ---------------------------------------------------------------------------
// mat_mul_seq
//   Time-multiplexed matrix-multiply sequencer. It computes
//   OUT(IxK) = LHS(IxJ) * RHS(JxK) with a single shared, pipelined vec_dot
//   unit (VEC_SIZE = J). The sequencer accepts one operand pair, issues one
//   row/column dot product per cycle in row-major order, collects the
//   returned results into the output matrix register and then presents that
//   register over a valid/ready handshake.
//
//   Packing: element (r,c) of an RxC matrix sits at [(r*C+c)*FW +: FW];
//            element j of a vector sits at [j*FW +: FW].
//
// Parameters
//   FW          float element width (must match the attached vec_dot)
//   I, J, K     matrix dimensions (J is the vec_dot vector length)
//   DOT_LATENCY clocks from dot_lhs/dot_rhs to dot_out of vec_dot (>= 1)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset; aborts any job in progress
//   in_valid   operand pair valid
//   in_ready   high only in IDLE
//   lhs, rhs   operand matrices, sampled on the accepting edge only
//   dot_lhs    row vector to vec_dot
//   dot_rhs    column vector to vec_dot
//   dot_issue  dot_lhs/dot_rhs carry a live issue this cycle
//   dot_out    vec_dot result, captured bit-exact
//   out_valid  result matrix valid (DONE state)
//   out_ready  consumer takes the result
//   out        result matrix register
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module mat_mul_seq #(
    parameter int FW          = 32,
    parameter int I           = 4,
    parameter int J           = 4,
    parameter int K           = 4,
    parameter int DOT_LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [I*J*FW-1:0]   lhs,
    input  logic [J*K*FW-1:0]   rhs,
    output logic [J*FW-1:0]     dot_lhs,
    output logic [J*FW-1:0]     dot_rhs,
    output logic                dot_issue,
    input  logic [FW-1:0]       dot_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [I*K*FW-1:0]   out,
    output logic                busy
);

    localparam int N  = I * K;
    localparam int IW = $clog2(N + 1);
    localparam int RW = (I > 1) ? $clog2(I) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // Tag travelling alongside a dot product through vec_dot's latency.
    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
    } tag_t;

    state_t              state;
    logic [I*J*FW-1:0]   lhs_q;
    logic [J*K*FW-1:0]   rhs_q;
    logic [RW-1:0]       row;        // row of the next issue
    logic [CW-1:0]       col;        // column of the next issue
    logic [IW-1:0]       cnt;        // issues launched so far
    logic [IW-1:0]       issue_idx;  // flat index of the issue on dot_*
    tag_t                pipe [DOT_LATENCY];
    tag_t                cap;
    logic                last_cap;

    function automatic logic [J*FW-1:0] row_of(input logic [I*J*FW-1:0] m,
                                               input int unsigned r);
        logic [J*FW-1:0] v;
        v = '0;
        for (int j = 0; j < J; j++)
            v[j*FW +: FW] = m[(r*J + j)*FW +: FW];
        return v;
    endfunction

    function automatic logic [J*FW-1:0] col_of(input logic [J*K*FW-1:0] m,
                                               input int unsigned c);
        logic [J*FW-1:0] v;
        v = '0;
        for (int j = 0; j < J; j++)
            v[j*FW +: FW] = m[(j*K + c)*FW +: FW];
        return v;
    endfunction

    // The oldest tag lines up with the dot_out of the issue it describes.
    assign cap      = pipe[DOT_LATENCY-1];
    assign last_cap = cap.valid && (cap.idx == IW'(N - 1));

    // NOTE: operand latches are plain data registers with no reset; they are
    // always written on accept before anything reads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            lhs_q <= lhs;
            rhs_q <= rhs;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dot_issue <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            dot_lhs   <= '0;
            dot_rhs   <= '0;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            issue_idx <= '0;
            for (int s = 0; s < DOT_LATENCY; s++)
                pipe[s] <= '0;
        end else begin
            pipe[0] <= tag_t'{dot_issue, issue_idx};
            for (int s = 1; s < DOT_LATENCY; s++)
                pipe[s] <= pipe[s-1];

            if (cap.valid)
                out[int'(cap.idx)*FW +: FW] <= dot_out;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Issue 0 goes out straight from the inputs so the
                        // first dot product lands in the cycle after accept.
                        dot_lhs   <= row_of(lhs, 0);
                        dot_rhs   <= col_of(rhs, 0);
                        dot_issue <= 1'b1;
                        issue_idx <= '0;
                        cnt       <= IW'(1);
                        if (K == 1) begin
                            row <= RW'(1);
                            col <= '0;
                        end else begin
                            row <= '0;
                            col <= CW'(1);
                        end
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == IW'(N)) begin
                        dot_issue <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        dot_lhs   <= row_of(lhs_q, int'(row));
                        dot_rhs   <= col_of(rhs_q, int'(col));
                        issue_idx <= cnt;
                        cnt       <= cnt + 1'b1;
                        if (col == CW'(K - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (last_cap) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
